// File: rtl/peak_detector.sv
// peak_detector: windowed max/min/peak-to-peak measurement with a hysteresis
// rising-crossing counter, fed by the moving-average filter's sample stream.
//
// Ports:
//   Clk, Reset (async, active-high)
//   enable_n     - filter sample strobe (low = filter loads Z on this edge)
//   Z            - signed filter output, captured one edge after the strobe
//   th_hi, th_lo - signed hysteresis thresholds
//   Max, Min     - signed extremes of the last completed window
//   P2P          - unsigned Max - Min of the last completed window (9 bits)
//   Rises        - rising crossings counted in the last completed window
//   above        - current hysteresis state (1 = ABOVE)
//   rise         - one-cycle pulse on each BELOW->ABOVE transition
//   window_done  - one-cycle pulse when Max/Min/P2P/Rises update
module peak_detector #(
  parameter int WINDOW = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              enable_n,
  input  logic signed [7:0] Z,
  input  logic signed [7:0] th_hi,
  input  logic signed [7:0] th_lo,
  output logic signed [7:0] Max,
  output logic signed [7:0] Min,
  output logic        [8:0] P2P,
  output logic        [7:0] Rises,
  output logic              above,
  output logic              rise,
  output logic              window_done
);

  localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  typedef enum logic {
    BELOW = 1'b0,
    ABOVE = 1'b1
  } state_t;

  state_t state_q;
  state_t state_nxt;
  logic   rise_nxt;

  // The filter updates Z on the strobe edge, so the sample is taken one
  // edge later, when the delayed strobe is high.
  logic strobe_d;

  logic        [CW-1:0] cnt;
  logic signed [7:0]    run_max;
  logic signed [7:0]    run_min;
  logic        [7:0]    run_rises;

  logic                 first;
  logic signed [7:0]    fold_max;
  logic signed [7:0]    fold_min;
  logic        [7:0]    fold_rises;
  logic        [8:0]    fold_p2p;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      strobe_d <= 1'b0;
    end else begin
      strobe_d <= ~enable_n;
    end
  end

  // Hysteresis comparator state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= BELOW;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; only evaluated on a capture so gaps leave it frozen.
  always_comb begin
    state_nxt = state_q;
    rise_nxt  = 1'b0;
    if (strobe_d) begin
      case (state_q)
        BELOW: begin
          if (Z >= th_hi) begin
            state_nxt = ABOVE;
            rise_nxt  = 1'b1;
          end
        end
        ABOVE: begin
          if (Z < th_lo) begin
            state_nxt = BELOW;
          end
        end
        default: state_nxt = BELOW;
      endcase
    end
  end

  assign above = (state_q == ABOVE);

  // Fold the current sample into the running window. On the first sample the
  // running values are discarded, so a new window never sees stale data.
  always_comb begin
    first      = (cnt == '0);
    fold_max   = (first || (Z > run_max)) ? Z : run_max;
    fold_min   = (first || (Z < run_min)) ? Z : run_min;
    fold_rises = (first ? 8'd0 : run_rises) + {7'd0, rise_nxt};
    // Sign-extend before subtracting: the span can reach 255.
    fold_p2p   = {fold_max[7], fold_max} - {fold_min[7], fold_min};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt         <= '0;
      run_max     <= '0;
      run_min     <= '0;
      run_rises   <= '0;
      Max         <= '0;
      Min         <= '0;
      P2P         <= '0;
      Rises       <= '0;
      rise        <= 1'b0;
      window_done <= 1'b0;
    end else begin
      rise        <= rise_nxt;
      window_done <= 1'b0;
      if (strobe_d) begin
        run_max   <= fold_max;
        run_min   <= fold_min;
        run_rises <= fold_rises;
        if (cnt == LAST) begin
          cnt         <= '0;
          Max         <= fold_max;
          Min         <= fold_min;
          P2P         <= fold_p2p;
          Rises       <= fold_rises;
          window_done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
